mem_access_arbiter: RTL and testbench

MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

---
 rtl/mem_access_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_access_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port 16x4 synchronous memory.
// Each transaction walks IDLE -> ISSUE -> WAIT -> RESP; every output is registered.
module mem_access_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [3:0] wdata0,
    input  logic [3:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] rdata0,
    output logic [3:0] rdata1,
    output logic       mem_en,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [3:0] mem_din,
    input  logic [3:0] mem_dout,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       win_q, win_d;
    logic       we_q, we_d;
    logic       last_q, last_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic [3:0] rdata0_q, rdata0_d;
    logic [3:0] rdata1_q, rdata1_d;
    logic       mem_en_q, mem_en_d;
    logic       mem_we_q, mem_we_d;
    logic [3:0] mem_addr_q, mem_addr_d;
    logic [3:0] mem_din_q, mem_din_d;
    logic       busy_q, busy_d;
    logic       pick;

    // On a tie the requester not served last wins.
    always_comb begin
        pick = req1;
        if (req0 && req1) begin
            pick = ~last_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        last_d     = last_q;
        gnt_d      = 2'b00;
        done_d     = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        mem_en_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d     = ISSUE;
                    win_d       = pick;
                    we_d        = pick ? we1 : we0;
                    mem_addr_d  = pick ? addr1 : addr0;
                    mem_din_d   = pick ? wdata1 : wdata0;
                    gnt_d[pick] = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = pick ? we1 : we0;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Memory read data is valid in this cycle, one clock after the enable.
                state_d = RESP;
                last_d  = win_q;
                if (!we_q) begin
                    if (win_q) begin
                        rdata1_d = mem_dout;
                    end else begin
                        rdata0_d = mem_dout;
                    end
                end
            end
            RESP: begin
                state_d       = IDLE;
                done_d[win_q] = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            last_q     <= 1'b1;
            gnt_q      <= 2'b00;
            done_q     <= 2'b00;
            rdata0_q   <= 4'h0;
            rdata1_q   <= 4'h0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 4'h0;
            mem_din_q  <= 4'h0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            mem_en_q   <= mem_en_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt0     = gnt_q[0];
    assign gnt1     = gnt_q[1];
    assign done0    = done_q[0];
    assign done1    = done_q[1];
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: a 16x4 memory model, a transaction-level reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_mem_access_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [3:0] addr0 = 4'h0, addr1 = 4'h0, wdata0 = 4'h0, wdata1 = 4'h0;
    logic       gnt0, gnt1, done0, done1, mem_en, mem_we, busy;
    logic [3:0] rdata0, rdata1, mem_addr, mem_din;
    logic [3:0] mem_dout = 4'h0;

    int checks = 0;
    int errors = 0;

    mem_access_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous memory seen by the arbiter.
    logic [3:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 4'h0;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_din;
            else        mem_dout      <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a grant opens a transaction at edge t; outputs follow
    // from the cycle offset k since t (gnt/mem_en at k=0, busy k<=2, done at k=3).
    int         cyc = 0;
    int         m_tg = 0;
    int         m_who = 0;
    int         next_ok = 0;
    int         m_last = 1;
    bit         m_act = 0;
    bit         m_we = 0;
    logic [3:0] m_addr = 4'h0;
    logic [3:0] e_rd0 = 4'h0, e_rd1 = 4'h0, e_maddr = 4'h0, e_mdin = 4'h0;
    logic [3:0] mm [16];
    initial for (int i = 0; i < 16; i++) mm[i] = 4'h0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act   = 0;
            next_ok = 0;
            m_last  = 1;
            e_rd0   = 4'h0;
            e_rd1   = 4'h0;
            e_maddr = 4'h0;
            e_mdin  = 4'h0;
        end else begin
            cyc++;
            if (m_act && (cyc - m_tg == 2)) begin
                m_last = m_who;
                if (!m_we) begin
                    if (m_who == 1) e_rd1 = mm[m_addr];
                    else            e_rd0 = mm[m_addr];
                end
            end
            if (cyc >= next_ok && (req0 || req1)) begin
                if (req0 && req1) m_who = 1 - m_last;
                else              m_who = req1 ? 1 : 0;
                m_act   = 1;
                m_tg    = cyc;
                next_ok = cyc + 4;
                m_we    = (m_who == 1) ? we1 : we0;
                m_addr  = (m_who == 1) ? addr1 : addr0;
                e_maddr = m_addr;
                e_mdin  = (m_who == 1) ? wdata1 : wdata0;
                if (m_we) mm[m_addr] = e_mdin;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int k;
            k = cyc - m_tg;
            chk("gnt0",     gnt0,     int'(m_act && k == 0 && m_who == 0));
            chk("gnt1",     gnt1,     int'(m_act && k == 0 && m_who == 1));
            chk("done0",    done0,    int'(m_act && k == 3 && m_who == 0));
            chk("done1",    done1,    int'(m_act && k == 3 && m_who == 1));
            chk("busy",     busy,     int'(m_act && k <= 2));
            chk("mem_en",   mem_en,   int'(m_act && k == 0));
            chk("mem_we",   mem_we,   int'(m_act && k == 0 && m_we));
            chk("mem_addr", mem_addr, e_maddr);
            chk("mem_din",  mem_din,  e_mdin);
            chk("rdata0",   rdata0,   e_rd0);
            chk("rdata1",   rdata1,   e_rd1);
        end
    end

    typedef struct { int c; int who; } gnt_rec_t;
    gnt_rec_t glog[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt0) glog.push_back('{cyc, 0});
            if (gnt1) glog.push_back('{cyc, 1});
        end
    end

    task automatic drive(input int r, input logic rq, input logic we,
                         input logic [3:0] a, input logic [3:0] d);
        if (r == 0) begin req0 = rq; we0 = we; addr0 = a; wdata0 = d; end
        else        begin req1 = rq; we1 = we; addr1 = a; wdata1 = d; end
    endtask

    // Called at a negedge; drops the request as soon as done is seen. lat = done - gnt.
    task automatic do_txn(input int r, input logic we, input logic [3:0] a,
                          input logic [3:0] d, output int lat);
        int tg;
        tg  = -100;
        lat = -1;
        drive(r, 1'b1, we, a, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((r == 0) ? gnt0 : gnt1) tg = cyc;
            if ((r == 0) ? done0 : done1) begin
                lat = cyc - tg;
                break;
            end
        end
        if (r == 0) req0 = 1'b0; else req1 = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: requester %0d saw no done within 20 cycles", r);
        end
    endtask

    int lat0, lat1;
    bit seen;

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_rdata", {rdata1, rdata0}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle bus
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_busy_en_gnt_done", {busy, mem_en, gnt0, gnt1, done0, done1}, 0);
        end

        // Simultaneous reads after reset: requester 0 first, requester 1 four cycles later
        glog.delete();
        fork
            do_txn(0, 1'b0, 4'h3, 4'h0, lat0);
            do_txn(1, 1'b0, 4'h5, 4'h0, lat1);
        join
        chk("tie_count", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("tie_first", glog[0].who, 0);
            chk("tie_second", glog[1].who, 1);
            chk("tie_spacing", glog[1].c - glog[0].c, 4);
        end

        // Write then read by requester 0
        do_txn(0, 1'b1, 4'h3, 4'hA, lat0);
        chk("wr_latency", lat0, 3);
        do_txn(0, 1'b0, 4'h3, 4'h0, lat0);
        chk("rd_latency", lat0, 3);
        @(negedge clk);
        chk("rd_rdata0", rdata0, 4'hA);
        chk("rd_rdata1", rdata1, 4'h0);

        // Persistent contention: requester 0 was served last, so 1 leads
        glog.delete();
        drive(0, 1'b1, 1'b0, 4'h3, 4'h0);
        drive(1, 1'b1, 1'b0, 4'h3, 4'h0);
        repeat (16) @(negedge clk);
        drive(0, 1'b0, 1'b0, 4'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 4'h0);
        repeat (6) @(negedge clk);
        chk("rr_count", glog.size(), 4);
        if (glog.size() > 0) chk("rr_first", glog[0].who, 1);
        for (int i = 1; i < glog.size(); i++) begin
            chk("rr_alternate", glog[i].who, 1 - glog[i-1].who);
            chk("rr_spacing", glog[i].c - glog[i-1].c, 4);
        end
        chk("rr_rdata1", rdata1, 4'hA);

        // Requester 1 write whose inputs change right after grant
        drive(1, 1'b1, 1'b1, 4'hF, 4'h5);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gnt1) seen = 1;
        end
        chk("chg_gnt1_seen", seen, 1);
        addr1 = 4'h2;
        wdata1 = 4'h9;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done1) seen = 1;
        end
        chk("chg_done1_seen", seen, 1);
        req1 = 1'b0;
        do_txn(0, 1'b0, 4'hF, 4'h0, lat0);
        @(negedge clk);
        chk("chg_read_F", rdata0, 4'h5);
        do_txn(1, 1'b0, 4'h2, 4'h0, lat1);
        @(negedge clk);
        chk("chg_read_2", rdata1, 4'h0);

        // Reset during WAIT of a requester-1 read
        do_txn(1, 1'b0, 4'hF, 4'h0, lat1);
        @(negedge clk);
        chk("pre_rst_rdata1", rdata1, 4'h5);
        drive(1, 1'b1, 1'b0, 4'h3, 4'h0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (gnt1) seen = 1;
        end
        chk("abort_gnt1_seen", seen, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        req1 = 1'b0;
        #1;
        chk("abort_ctrl_zero", {gnt0, gnt1, done0, done1, busy, mem_en, mem_we}, 0);
        chk("abort_data_zero", {rdata0, rdata1, mem_addr, mem_din}, 0);
        @(negedge clk);
        chk("abort_no_done1", done1, 0);
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 4'h3, 4'h0);
        @(negedge clk);
        chk("post_rst_gnt0", gnt0, 1);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1;
        end
        chk("post_rst_done0", seen, 1);
        req0 = 1'b0;
        @(negedge clk);
        chk("post_rst_rdata0", rdata0, 4'hA);
        chk("post_rst_rdata1", rdata1, 4'h0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
